// File: rtl/mod_n_down_timer.sv
// Loadable modulo-N down-counter/timer: counts enabled ticks down to zero,
// pulses borrow_out at terminal count, then halts in DONE or auto-reloads.
module mod_n_down_timer #(
  parameter int MODULUS = 14,
  parameter int WIDTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             auto_reload,
  input  logic             count_enable,
  output logic [WIDTH-1:0] count,
  output logic             borrow_out,
  output logic             busy,
  output logic             done,
  output logic             load_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] reload_r;
  logic             load_oor;
  logic [WIDTH-1:0] load_sat;

  // Out-of-range loads saturate to the top legal count.
  assign load_oor = ({1'b0, load_value} >= MOD_EXT);
  assign load_sat = load_oor ? MAX_COUNT : load_value;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every register, including reload_r, has an async reset value so
      // the timer restarts from a known interval with no prior load.
      state      <= IDLE;
      count      <= '0;
      reload_r   <= MAX_COUNT;
      borrow_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_err   <= 1'b0;
    end else if (load) begin
      state      <= IDLE;
      count      <= load_sat;
      reload_r   <= load_sat;
      load_err   <= load_oor;
      borrow_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      borrow_out <= 1'b0;
      unique case (state)
        IDLE: begin
          // After a load count already equals reload_r; after reset this
          // brings in the default interval.
          if (start) begin
            count <= reload_r;
            state <= RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        RUN: begin
          if (count_enable) begin
            if (count != '0) begin
              count <= count - ONE;
            end else begin
              borrow_out <= 1'b1;
              if (auto_reload) begin
                count <= reload_r;
              end else begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          if (start) begin
            count <= reload_r;
            state <= RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_n_down_timer.sv
// Self-checking bench for mod_n_down_timer: directed scenarios plus random
// stimulus, compared against a behavioural model of the timer.
module tb_mod_n_down_timer;

  localparam int MODULUS = 14;
  localparam int WIDTH   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             auto_reload;
  logic             count_enable;
  logic [WIDTH-1:0] count;
  logic             borrow_out;
  logic             busy;
  logic             done;
  logic             load_err;

  int n_checks = 0;
  int n_pass   = 0;

  mod_n_down_timer #(.MODULUS(MODULUS), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .load(load), .load_value(load_value),
    .start(start), .auto_reload(auto_reload), .count_enable(count_enable),
    .count(count), .borrow_out(borrow_out), .busy(busy), .done(done),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1);
  end

  // Behavioural model: mode, remaining ticks, programmed interval.
  typedef enum {M_IDLE, M_RUN, M_DONE} mode_t;
  mode_t m_mode;
  int    m_count, m_interval;
  bit    m_borrow, m_err;

  function automatic void model_reset();
    m_mode = M_IDLE; m_count = 0; m_interval = MODULUS - 1;
    m_borrow = 0; m_err = 0;
  endfunction

  function automatic void model_step(bit l, int lv, bit s, bit ar, bit ce);
    m_borrow = 0;
    if (l) begin
      m_err      = (lv >= MODULUS);
      m_interval = m_err ? MODULUS - 1 : lv;
      m_count    = m_interval;
      m_mode     = M_IDLE;
    end else if (m_mode != M_RUN) begin
      if (s) begin
        m_count = m_interval;
        m_mode  = M_RUN;
      end
    end else if (ce) begin
      if (m_count > 0) m_count = m_count - 1;
      else begin
        m_borrow = 1;
        if (ar) m_count = m_interval;
        else    m_mode  = M_DONE;
      end
    end
  endfunction

  function automatic logic [8:0] exp_vec();
    logic [3:0] c;
    c = 4'(m_count);
    return {c, m_borrow, m_mode == M_RUN, m_mode == M_DONE, m_err};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {count, borrow_out, busy, done, load_err};
  endfunction

  // Apply one cycle of inputs, clock it, advance the model.
  task automatic step(input bit l, input int lv, input bit s, input bit ar, input bit ce);
    load = l; load_value = 4'(lv); start = s; auto_reload = ar; count_enable = ce;
    @(posedge clk);
    #1;
    model_step(l, lv, s, ar, ce);
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 0; load_value = 0; start = 0; auto_reload = 0; count_enable = 0;
    model_reset();
    #2;
    n_checks++;
    if (dut_vec() !== 9'b0) $display("FAIL reset_async: got %b required %b", dut_vec(), 9'b0);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (dut_vec() !== 9'b0) $display("FAIL reset_held: got %b required %b", dut_vec(), 9'b0);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_default_run();
    step(0, 0, 1, 0, 0);
    n_checks++;
    if (count !== 4'd13 || busy !== 1'b1) $display("FAIL default_start: got count=%0d busy=%b required 13 1", count, busy);
    else n_pass++;
    for (int i = 1; i <= 14; i++) begin
      step(0, 0, 0, 0, 1);
      n_checks++;
      if (dut_vec() !== exp_vec() || borrow_out !== (i == 14) || count !== 4'((i < 14) ? 13 - i : 0))
        $display("FAIL default_tick%0d: got %b required %b", i, dut_vec(), exp_vec());
      else n_pass++;
    end
    step(0, 0, 0, 0, 0);
    n_checks++;
    if ({done, busy, count, borrow_out} !== {1'b1, 1'b0, 4'd0, 1'b0})
      $display("FAIL default_done: got done=%b busy=%b count=%0d borrow=%b required 1 0 0 0", done, busy, count, borrow_out);
    else n_pass++;
  endtask

  task automatic test_auto_reload();
    step(1, 3, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    for (int k = 1; k <= 8; k++) begin
      step(0, 0, 0, 1, 1);
      n_checks++;
      if (dut_vec() !== exp_vec() || borrow_out !== (k % 4 == 0) || busy !== 1'b1 || done !== 1'b0
          || count !== 4'((k % 4 == 0) ? 3 : 3 - (k % 4)))
        $display("FAIL autoreload_tick%0d: got %b required %b", k, dut_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_load_range();
    step(1, 15, 0, 0, 0);
    n_checks++;
    if (count !== 4'd13 || load_err !== 1'b1) $display("FAIL load_oor: got count=%0d err=%b required 13 1", count, load_err);
    else n_pass++;
    step(1, 5, 0, 0, 0);
    n_checks++;
    if (count !== 4'd5 || load_err !== 1'b0) $display("FAIL load_ok: got count=%0d err=%b required 5 0", count, load_err);
    else n_pass++;
  endtask

  task automatic test_ignored_ticks();
    int gap;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    n_checks++;
    if (count !== 4'd5 || busy !== 1'b0) $display("FAIL idle_ticks: got count=%0d busy=%b required 5 0", count, busy);
    else n_pass++;
    step(0, 0, 1, 0, 0);
    for (int t = 0; t < 6; t++) begin
      gap = $urandom_range(1, 3);
      for (int g = 0; g < gap; g++) begin
        step(0, 0, 0, 0, 0);
        n_checks++;
        if (dut_vec() !== exp_vec() || borrow_out !== 1'b0)
          $display("FAIL gap_idlecycle: got %b required %b", dut_vec(), exp_vec());
        else n_pass++;
      end
      step(0, 0, 0, 0, 1);
      n_checks++;
      if (dut_vec() !== exp_vec() || count !== 4'((t < 5) ? 4 - t : 0))
        $display("FAIL gap_tick%0d: got %b required %b", t, dut_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if ({borrow_out, done} !== 2'b11) $display("FAIL gap_terminal: got borrow=%b done=%b required 1 1", borrow_out, done);
    else n_pass++;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    n_checks++;
    if ({count, done, borrow_out} !== {4'd0, 1'b1, 1'b0})
      $display("FAIL done_ticks: got count=%0d done=%b borrow=%b required 0 1 0", count, done, borrow_out);
    else n_pass++;
  endtask

  task automatic test_priority();
    step(1, 10, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    n_checks++;
    if (count !== 4'd6) $display("FAIL midrun_pre: got count=%0d required 6", count);
    else n_pass++;
    step(1, 9, 0, 0, 1);
    n_checks++;
    if ({count, busy, done} !== {4'd9, 1'b0, 1'b0}) $display("FAIL midrun_load: got count=%0d busy=%b done=%b required 9 0 0", count, busy, done);
    else n_pass++;
    step(1, 7, 1, 0, 0);
    n_checks++;
    if ({count, busy} !== {4'd7, 1'b0}) $display("FAIL load_beats_start: got count=%0d busy=%b required 7 0", count, busy);
    else n_pass++;
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);
    n_checks++;
    if (done !== 1'b1) $display("FAIL reach_done: got done=%b required 1", done);
    else n_pass++;
    step(0, 0, 1, 0, 0);
    n_checks++;
    if ({count, busy, done} !== {4'd7, 1'b1, 1'b0}) $display("FAIL done_restart: got count=%0d busy=%b done=%b required 7 1 0", count, busy, done);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    step(1, 8, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    n_checks++;
    if ({count, busy} !== {4'd4, 1'b1}) $display("FAIL arst_pre: got count=%0d busy=%b required 4 1", count, busy);
    else n_pass++;
    count_enable = 0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (dut_vec() !== 9'b0) $display("FAIL arst_midrun: got %b required %b", dut_vec(), 9'b0);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    n_checks++;
    if ({count, busy} !== {4'd12, 1'b1}) $display("FAIL arst_restart: got count=%0d busy=%b required 12 1", count, busy);
    else n_pass++;
  endtask

  task automatic test_random();
    bit l, s, ar, ce;
    int lv;
    for (int i = 0; i < 400; i++) begin
      l  = ($urandom_range(0, 15) == 0);
      lv = $urandom_range(0, 15);
      s  = ($urandom_range(0, 7) == 0);
      ar = $urandom_range(0, 1);
      ce = ($urandom_range(0, 3) != 0);
      step(l, lv, s, ar, ce);
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL random_cycle%0d: got %b required %b", i, dut_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_auto_reload();
    test_load_range();
    test_ignored_ticks();
    test_priority();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
